uart_frame_parser: RTL and testbench

Byte-level framing stage placed directly downstream of the UART receiver. It consumes the receiver's 8-bit data and one-cycle valid pulse, and recognises frames of the form 0x55 0xAA LEN PAYLOAD[LEN] CSUM. It buffers each payload and validates the checksum before releasing anything. Only validated payloads are streamed out over a valid/ready interface; malformed, corrupted or stalled frames are discarded with an error code.

---
 rtl/uart_frame_parser.sv | 141 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Byte framing stage behind a UART receiver: parses 0x55 0xAA LEN PAYLOAD CSUM frames and
// streams checksum-validated payloads out over valid/ready.
module uart_frame_parser #(
   parameter int unsigned MAX_LEN        = 16,
   parameter int unsigned TIMEOUT_CYCLES = 104160
) (
   input  logic       system_clk,
   input  logic       system_rst,
   input  logic [7:0] in_data,
   input  logic       in_flag,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       drop
);

   localparam int unsigned IdxW    = $clog2(MAX_LEN + 1);
   localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
   localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);
   localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StHdr2, StLen, StPayload, StCsum, StDrain
   } state_e;

   state_e            state_q;
   logic [7:0]        mem_q [MAX_LEN];
   logic [IdxW-1:0]   len_q;
   logic [IdxW-1:0]   wr_idx_q;
   logic [IdxW-1:0]   rd_idx_q;
   logic [IdxW-1:0]   rd_next;
   logic [7:0]        sum_q;
   logic [31:0]       tmo_q;

   assign rd_next = rd_idx_q + IdxOne;

   always_ff @(posedge system_clk) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      drop      <= 1'b0;
      if (system_rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         sum_q     <= '0;
         tmo_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         err_code  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_flag && in_data == 8'h55) begin
                  state_q <= StHdr2;
                  tmo_q   <= '0;
               end
            end
            StDrain: begin
               // Bytes arriving while the buffer drains are dropped, not parsed
               drop <= in_flag;
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state_q   <= StIdle;
                  end else begin
                     rd_idx_q <= rd_next;
                     out_data <= mem_q[rd_next[AW-1:0]];
                     out_last <= (rd_next == len_q - IdxOne);
                  end
               end
            end
            default: begin
               if (in_flag) begin
                  // A byte always wins over an expiring timeout in the same cycle
                  tmo_q <= '0;
                  case (state_q)
                     StHdr2: begin
                        if (in_data == 8'hAA) begin
                           state_q <= StLen;
                        end else if (in_data != 8'h55) begin
                           state_q <= StIdle;
                        end
                     end
                     StLen: begin
                        if (in_data == 8'd0 || in_data > MaxLenB) begin
                           frame_err <= 1'b1;
                           err_code  <= 2'd1;
                           state_q   <= StIdle;
                        end else begin
                           len_q    <= IdxW'(in_data);
                           sum_q    <= in_data;
                           wr_idx_q <= '0;
                           state_q  <= StPayload;
                        end
                     end
                     StPayload: begin
                        mem_q[wr_idx_q[AW-1:0]] <= in_data;
                        sum_q    <= sum_q + in_data;
                        wr_idx_q <= wr_idx_q + IdxOne;
                        if (wr_idx_q == len_q - IdxOne) begin
                           state_q <= StCsum;
                        end
                     end
                     StCsum: begin
                        if (in_data == sum_q) begin
                           frame_ok  <= 1'b1;
                           rd_idx_q  <= '0;
                           out_valid <= 1'b1;
                           out_data  <= mem_q[0];
                           out_last  <= (len_q == IdxOne);
                           state_q   <= StDrain;
                        end else begin
                           frame_err <= 1'b1;
                           err_code  <= 2'd2;
                           state_q   <= StIdle;
                        end
                     end
                     default: state_q <= StIdle;
                  endcase
               end else if (tmo_q == TmoLast) begin
                  frame_err <= 1'b1;
                  err_code  <= 2'd3;
                  tmo_q     <= '0;
                  state_q   <= StIdle;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames from the test plan, then random traffic.
module tb_uart_frame_parser;

   localparam int MaxLen = 16;
   localparam int Tmo    = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_flag = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       drop;

   uart_frame_parser #(
      .MAX_LEN        (MaxLen),
      .TIMEOUT_CYCLES (Tmo)
   ) dut (
      .system_clk (clk),
      .system_rst (rst),
      .in_data    (in_data),
      .in_flag    (in_flag),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .drop       (drop)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         evt_q[$];      // 0 = frame_ok, 1..3 = frame_err with that code
   logic [8:0] dat_q[$];      // {last, data}
   logic [7:0] pl[$];
   int         exp_drop = 0;
   int         got_drop = 0;
   int         ready_mode = 0; // 0 hold 1, 1 random, 2 toggle

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int rg(input int lo, input int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            2:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(3, 0) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event or a transfer
   initial begin
      logic       prev_stall;
      logic [8:0] prev_out;
      int         e;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (frame_ok) begin
               if (evt_q.size() == 0) check("unexpected_frame_ok", 1, 0);
               else begin
                  e = evt_q.pop_front();
                  check("frame_ok_event", 0, e);
               end
            end
            if (frame_err) begin
               if (evt_q.size() == 0) check("unexpected_frame_err", int'(err_code), 0);
               else begin
                  e = evt_q.pop_front();
                  check("frame_err_code", int'(err_code), e);
               end
            end
            if (drop) got_drop++;
            if (prev_stall)
               check("stall_hold", int'({out_valid, out_last, out_data}), int'({1'b1, prev_out}));
            if (out_valid && out_ready) begin
               if (dat_q.size() == 0) check("unexpected_out_byte", int'({out_last, out_data}), 0);
               else check("out_byte", int'({out_last, out_data}), int'(dat_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      in_data = b;
      in_flag = 1'b1;
      tick();
      in_flag = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic wait_idle();
      int c = 0;
      while ((out_valid || dat_q.size() != 0 || evt_q.size() != 0) && c < 2000) begin
         tick();
         c++;
      end
      check("idle_within_bound", int'(c < 2000), 1);
   endtask

   task automatic fill_payload(input int n);
      pl.delete();
      repeat (n) pl.push_back(8'($urandom));
   endtask

   task automatic send_frame(input bit bad, input bit resync, input int gmin, input int gmax,
                             input bit inject, input bit measure);
      logic [7:0] sum;
      int         n;
      int         cnt;
      n   = pl.size();
      sum = 8'(n);
      foreach (pl[i]) sum += pl[i];
      if (bad) evt_q.push_back(2);
      else begin
         evt_q.push_back(0);
         foreach (pl[i]) dat_q.push_back({(i == n - 1), pl[i]});
      end
      send_byte(8'h55, rg(gmin, gmax));
      if (resync) send_byte(8'h55, rg(gmin, gmax));
      send_byte(8'hAA, rg(gmin, gmax));
      send_byte(8'(n), rg(gmin, gmax));
      foreach (pl[i]) send_byte(pl[i], rg(gmin, gmax));
      send_byte(bad ? sum + 8'(rg(1, 255)) : sum, rg(gmin, gmax));
      if (measure) begin
         cnt = 0;
         while (out_valid && cnt < 1000) begin
            cnt++;
            tick();
         end
         check("drain_cycles", cnt, n);
      end
      if (inject && !bad && out_valid) begin
         exp_drop++;
         send_byte(8'($urandom), 0);
      end
      wait_idle();
   endtask

   task automatic send_badlen(input logic [7:0] l);
      evt_q.push_back(1);
      send_byte(8'h55, rg(0, 2));
      send_byte(8'hAA, rg(0, 2));
      send_byte(l, rg(0, 2));
      wait_idle();
   endtask

   task automatic send_timeout(input int stage);
      int n = rg(1, MaxLen);
      evt_q.push_back(3);
      send_byte(8'h55, rg(0, 2));
      if (stage >= 1) send_byte(8'hAA, rg(0, 2));
      if (stage >= 2) send_byte(8'(n), rg(0, 2));
      if (stage >= 3) repeat (rg(0, n - 1)) send_byte(8'($urandom), rg(0, 2));
      repeat (Tmo + 2) tick();
      wait_idle();
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] x;
      int         k;
      rst = 1'b1;
      tick();
      tick();
      check("reset_outputs", int'({out_data, out_valid, out_last, frame_ok, frame_err, err_code,
                                   drop}), 0);
      rst = 1'b0;
      tick();

      // Good frame, full-rate drain
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(1'b1, 1'b0, 0, 1, 1'b0, 1'b0);
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(1'b0, 1'b0, 0, 1, 1'b0, 1'b1);

      send_badlen(8'h00);
      send_badlen(8'h11);
      pl = '{8'h7F};
      send_frame(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);

      // Aborted header: 55 12 AA 01 7F 80 yields nothing
      pl = '{8'h55, 8'h12, 8'hAA, 8'h01, 8'h7F, 8'h80};
      foreach (pl[i]) send_byte(pl[i], 0);
      repeat (20) tick();
      check("err_code_hold", int'(err_code), 1);
      check("abort_no_output", int'(out_valid), 0);

      // Backpressure with a byte injected during drain
      ready_mode = 2;
      pl = '{8'hA0, 8'hB0};
      send_frame(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
      ready_mode = 0;

      // Silence timeout, then bytes arriving exactly on the timeout cycle
      evt_q.push_back(3);
      send_byte(8'h55, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h02, 0);
      send_byte(8'h10, 0);
      repeat (Tmo + 2) tick();
      wait_idle();
      check("timeout_code", int'(err_code), 3);
      pl = '{8'h10, 8'h20};
      send_frame(1'b0, 1'b0, Tmo - 1, Tmo - 1, 1'b0, 1'b0);

      // Reset mid-payload after an error so err_code has something to clear
      send_badlen(8'hFF);
      send_byte(8'h55, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h05, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      rst = 1'b1;
      tick();
      check("midframe_reset_outputs", int'({out_data, out_valid, out_last, frame_ok, frame_err,
                                            err_code, drop}), 0);
      rst = 1'b0;
      tick();
      fill_payload(4);
      send_frame(1'b0, 1'b0, 0, 2, 1'b0, 1'b1);

      // Random traffic
      ready_mode = 1;
      for (int s = 0; s < 150; s++) begin
         k = rg(0, 19);
         if (k < 6) begin
            fill_payload(rg(1, MaxLen));
            send_frame(1'b0, 1'b0, 0, 3, rg(0, 1) == 1, 1'b0);
         end else if (k < 8) begin
            fill_payload(rg(1, MaxLen));
            send_frame(1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
         end else if (k < 11) begin
            fill_payload(rg(1, MaxLen));
            send_frame(1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
         end else if (k < 13) begin
            send_badlen(rg(0, 1) == 1 ? 8'h00 : 8'(rg(MaxLen + 1, 255)));
         end else if (k < 15) begin
            x = 8'($urandom);
            while (x == 8'h55 || x == 8'hAA) x = 8'($urandom);
            send_byte(8'h55, rg(0, 3));
            send_byte(x, rg(0, 3));
         end else if (k < 18) begin
            x = 8'($urandom);
            while (x == 8'h55) x = 8'($urandom);
            send_byte(x, rg(0, 3));
         end else begin
            send_timeout(rg(0, 3));
         end
      end

      wait_idle();
      repeat (4) tick();
      check("pending_bytes", dat_q.size(), 0);
      check("pending_events", evt_q.size(), 0);
      check("drop_count", got_drop, exp_drop);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
